// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, selects the next fetch address from
// opcode/jump field/zero flag, and provides CALL/RET through a return-address stack.
module pc_sequencer #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [5:0]                         opcode,
  input  logic [PC_WIDTH-1:0]                dir_salto,
  input  logic                               z,
  input  logic                               stall,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_level,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_CALL = 6'b000111;
  localparam logic [5:0] OP_RET  = 6'b001000;

  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);
  localparam logic [SPW-1:0]      SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0]      SP_FULL = SPW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [SPW-1:0]      sp_q, sp_d, sp_dec;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                push;
  logic                full, empty;
  logic [IW-1:0]       push_idx, pop_idx;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);
  assign pc_inc   = pc_q + PC_ONE;
  assign sp_dec   = sp_q - SP_ONE;
  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = sp_dec[IW-1:0];

  // Next-state selection; stall freezes every piece of architectural state.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!stall) begin
      pc_d = pc_inc;
      case (opcode)
        OP_J:   pc_d = dir_salto;
        OP_JZ:  if (z)  pc_d = dir_salto;
        OP_JNZ: if (!z) pc_d = dir_salto;
        OP_CALL: begin
          if (!full) begin
            push = 1'b1;
            pc_d = dir_salto;
            sp_d = sp_q + SP_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pc_d = stack_mem[pop_idx];
            sp_d = sp_dec;
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries at or above sp_level are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_mem[push_idx] <= pc_inc;
  end

  assign pc            = pc_q;
  assign sp_level      = sp_q;
  assign stack_full    = full;
  assign stack_empty   = empty;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model feeds an expected queue
// that is compared against the DUT one cycle after each instruction.
module tb_pc_sequencer;

  localparam int PW  = 10;
  localparam int SD  = 4;
  localparam int SPW = $clog2(SD + 1);
  localparam int W   = PW + SPW + 4;

  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_CALL = 6'b000111;
  localparam logic [5:0] OP_RET  = 6'b001000;
  localparam logic [5:0] OP_ALU  = 6'b010010;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [5:0]     opcode = '0;
  logic [PW-1:0]  dir_salto = '0;
  logic           z = 1'b0;
  logic           stall = 1'b0;
  logic [PW-1:0]  pc;
  logic [SPW-1:0] sp_level;
  logic           stack_full, stack_empty, err_overflow, err_underflow;

  pc_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .dir_salto(dir_salto), .z(z),
    .stall(stall), .pc(pc), .sp_level(sp_level), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_stack[$];
  logic          m_ovf, m_unf;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] model_vec();
    logic [SPW-1:0] sp;
    sp = SPW'(m_stack.size());
    return {m_pc, sp, (m_stack.size() == SD), (m_stack.size() == 0), m_ovf, m_unf};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {pc, sp_level, stack_full, stack_empty, err_overflow, err_underflow};
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one instruction, advance the model, then compare after the edge.
  task automatic step(input logic [5:0] op, input logic [PW-1:0] tgt,
                      input logic zz, input logic st);
    logic [PW-1:0] inc;
    logic [W-1:0]  exp_v, got_v;
    opcode = op; dir_salto = tgt; z = zz; stall = st;
    inc = m_pc + PW'(1);
    if (!st) begin
      case (op)
        OP_J:   m_pc = tgt;
        OP_JZ:  m_pc = zz ? tgt : inc;
        OP_JNZ: m_pc = zz ? inc : tgt;
        OP_CALL: begin
          if (m_stack.size() < SD) begin
            m_stack.push_back(inc);
            m_pc = tgt;
          end else begin
            m_pc = inc;
            m_ovf = 1'b1;
          end
        end
        OP_RET: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc = inc;
            m_unf = 1'b1;
          end
        end
        default: m_pc = inc;
      endcase
    end
    exp_q.push_back(model_vec());
    @(posedge clk); #1;
    got_v = dut_vec();
    exp_v = exp_q.pop_front();
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL step op=%b tgt=%h z=%b stall=%b: got pc/sp/f/e/ovf/unf=%h expected %h",
               op, tgt, zz, st, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_v;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(model_vec());
    exp_v = exp_q.pop_front();
    n_vec++;
    if (dut_vec() !== exp_v || exp_v !== {10'd0, 3'd0, 4'b0100}) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_v);
    end
  endtask

  task automatic test_alu_count();
    for (int i = 0; i < 5; i++) step(OP_ALU, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'd5 || stack_empty !== 1'b1) begin
      n_err++;
      $display("FAIL alu_count: got pc=%0d empty=%b expected pc=5 empty=1", pc, stack_empty);
    end
  endtask

  task automatic test_wrap();
    step(OP_J, 10'd1023, 1'b0, 1'b0);
    step(OP_ALU, 10'h155, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 10'd0) begin
      n_err++;
      $display("FAIL pc_wrap: got %0d expected 0", pc);
    end
  endtask

  task automatic test_cond_jumps();
    step(OP_JZ, 10'h040, 1'b1, 1'b0);
    step(OP_ALU, '0, 1'b0, 1'b0);
    step(OP_JZ, 10'h300, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h042) begin
      n_err++;
      $display("FAIL jz_not_taken: got %h expected 042", pc);
    end
    step(OP_JNZ, 10'h100, 1'b0, 1'b0);
    step(OP_JNZ, 10'h222, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 10'h101) begin
      n_err++;
      $display("FAIL jnz_not_taken: got %h expected 101", pc);
    end
  endtask

  task automatic test_call_ret();
    step(OP_J, 10'h010, 1'b0, 1'b0);
    step(OP_CALL, 10'h200, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(OP_ALU, '0, 1'b0, 1'b0);
    step(OP_CALL, 10'h300, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h300 || sp_level !== 3'd2) begin
      n_err++;
      $display("FAIL nested_call: got pc=%h sp=%0d expected pc=300 sp=2", pc, sp_level);
    end
    step(OP_RET, '0, 1'b0, 1'b0);
    step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h011 || sp_level !== 3'd0) begin
      n_err++;
      $display("FAIL nested_ret: got pc=%h sp=%0d expected pc=011 sp=0", pc, sp_level);
    end
  endtask

  task automatic test_overflow();
    step(OP_J, 10'h070, 1'b0, 1'b0);
    step(OP_CALL, 10'h080, 1'b0, 1'b0);
    step(OP_CALL, 10'h0a0, 1'b0, 1'b0);
    step(OP_CALL, 10'h0c0, 1'b0, 1'b0);
    step(OP_CALL, 10'h0e0, 1'b0, 1'b0);
    step(OP_CALL, 10'h0f0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h0e1 || err_overflow !== 1'b1 || sp_level !== 3'd4 || stack_full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got pc=%h ovf=%b sp=%0d full=%b expected 0e1 1 4 1",
               pc, err_overflow, sp_level, stack_full);
    end
    for (int i = 0; i < 4; i++) step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h071 || err_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_unwind: got pc=%h unf=%b expected 071 0", pc, err_underflow);
    end
  endtask

  task automatic test_underflow();
    step(OP_J, 10'h020, 1'b0, 1'b0);
    step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h021 || err_underflow !== 1'b1 || sp_level !== 3'd0) begin
      n_err++;
      $display("FAIL underflow: got pc=%h unf=%b sp=%0d expected 021 1 0", pc, err_underflow, sp_level);
    end
    step(OP_CALL, 10'h030, 1'b0, 1'b0);
    step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h022 || err_underflow !== 1'b1) begin
      n_err++;
      $display("FAIL underflow_sticky: got pc=%h unf=%b expected 022 1", pc, err_underflow);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) step(OP_CALL, 10'h150, 1'b0, 1'b1);
    step(OP_CALL, 10'h150, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h150 || sp_level !== 3'd1) begin
      n_err++;
      $display("FAIL stall_release: got pc=%h sp=%0d expected 150 1", pc, sp_level);
    end
    step(OP_RET, '0, 1'b0, 1'b1);
    step(OP_RET, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(OP_J, 10'h3fe, 1'b0, 1'b0);
    step(OP_CALL, 10'h123, 1'b0, 1'b0);
    step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h3ff) begin
      n_err++;
      $display("FAIL call_ret_b2b: got %h expected 3ff", pc);
    end
    step(OP_CALL, 10'h200, 1'b0, 1'b0);
    step(OP_RET, '0, 1'b0, 1'b0);
    n_vec++;
    if (pc !== 10'h000) begin
      n_err++;
      $display("FAIL ret_addr_wrap: got %h expected 000", pc);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{OP_J, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_ALU, 6'b000000, 6'b111111};
    for (int i = 0; i < 60; i++)
      step(ops[$urandom_range(7, 0)], PW'($urandom_range(1023, 0)),
           1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0));
  endtask

  task automatic test_async_reset();
    logic [W-1:0] exp_v;
    step(OP_CALL, 10'h2a0, 1'b0, 1'b0);
    opcode = OP_CALL; dir_salto = 10'h111; stall = 1'b0;
    #3 reset = 1'b1;
    model_reset();
    #1;
    exp_q.push_back(model_vec());
    exp_v = exp_q.pop_front();
    n_vec++;
    if (dut_vec() !== exp_v) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_v);
    end
    @(posedge clk); #1 reset = 1'b0;
    step(OP_ALU, '0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_count();
    test_wrap();
    test_cond_jumps();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the basic CPU: owns the PC register, decides the next instruction address each cycle from the current opcode, the jump field and the ALU zero flag, and adds hardware subroutine support (CALL/RET) through an internal return-address stack. It sits between the instruction memory address port and the decoder, replacing the external PC register, incrementer and jump mux. It reports stack status and sticky error flags for misuse.

## Interface
- PC_WIDTH, 10, width of PC, jump field and stack entries
- STACK_DEPTH, 4, number of return-address entries (≥2)
- clk  in  1  system clock, rising-edge active
- reset  in  1  one clock; reset is asynchronous and active-high
- opcode  in  6  opcode field of the current instruction
- dir_salto  in  PC_WIDTH  jump/call target field of the current instruction
- z  in  1  registered zero flag from the ALU
- stall  in  1  hold request: freeze PC and stack this cycle
- pc  out  PC_WIDTH  current instruction address
- sp_level  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  out  1  sp_level == STACK_DEPTH
- stack_empty  out  1  sp_level == 0
- err_overflow  out  1  sticky: CALL issued with stack full
- err_underflow  out  1  sticky: RET issued with stack empty

## Operation
- Next-PC selection when stall=0, by opcode:
  - 000100 J: pc ← dir_salto.
  - 000101 JZ: pc ← dir_salto if z=1, else pc+1.
  - 000110 JNZ: pc ← dir_salto if z=0, else pc+1.
  - 000111 CALL: if not full, push pc+1, pc ← dir_salto, sp_level+1. If full: no push, pc ← pc+1, err_overflow ← 1.
  - 001000 RET: if not empty, pc ← top entry, sp_level−1. If empty: pc ← pc+1, err_underflow ← 1.
  - all other opcodes (ALU register/immediate forms, undefined): pc ← pc+1.
- pc+1 is modulo 2^PC_WIDTH; max value wraps to 0. Pushed return address wraps identically.
- Stack is LIFO; entries beyond sp_level are don't-care and never observable.
- stall=1 overrides everything: pc, stack contents, sp_level and error flags hold.
- Error flags are sticky; cleared only by reset. Setting one does not affect the other.
- Per cycle at most one stack operation occurs; there is no simultaneous push/pop.
- Combinational outputs: stack_full, stack_empty derive from sp_level only; no combinational path from opcode/z to any output.

## Timing
- Reset (asynchronous assert, released synchronously to clk by upstream): pc=0, sp_level=0, stack_full=0, stack_empty=1, err_overflow=0, err_underflow=0.
- All state updates on rising clk edge; opcode, dir_salto, z sampled on that edge.
- Latency: new pc visible one cycle after the instruction that caused it; one instruction per cycle, no bubbles.
- CALL followed immediately by RET in the next cycle returns to CALL address+1 in two cycles total.
- Reset asserted mid-operation (e.g. during a CALL cycle) discards the pending update; the stack is emptied and pc=0 from the assertion instant.
- stall asserted on the same edge as a CALL/RET: operation not performed; it executes on the first edge with stall=0 if the opcode is still presented.

## Test plan
- Reset then 5 cycles of opcode 010010 -> pc = 0,1,2,3,4,5; stack_empty=1, errors 0; preload pc to 1023 via J 1023, next ALU op -> pc=0.
- JZ target 0x040 with z=1 -> pc=0x040; JZ with z=0 from pc=0x041 -> pc=0x042; JNZ 0x100 with z=0 -> pc=0x100.
- CALL 0x200 from pc=0x010, CALL 0x300 from 0x205, RET, RET -> pc sequence 0x200, 0x300, 0x206, 0x011; sp_level 1,2,1,0.
- Five CALLs with STACK_DEPTH=4 -> fifth gives pc=caller+1, err_overflow=1, sp_level stays 4, stack_full=1; four RETs return correct addresses in reverse order.
- RET on empty stack at pc=0x020 -> pc=0x021, err_underflow=1, sp_level=0; flag stays 1 through later valid CALL/RET.
- stall=1 for 3 cycles during a CALL -> pc and sp_level frozen; stall drop -> CALL completes; async reset pulse mid-cycle -> pc=0, sp_level=0, flags cleared immediately.
